// File: rtl/arith_pkg.sv
// Shared types for the arithmetic op sequencer and its unit.
// Opcodes, FSM states, op-count sizing and a clamp helper.
package arith_pkg;

  localparam int MAX_OPS_DEF = 8;
  localparam int NUMOPS_W    = 4;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_MUL    = 2'd2,
    OP_PASS_A = 2'd3
  } au_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } seq_state_t;

  // Requested counts above the run limit are cut down to it.
  function automatic logic [NUMOPS_W-1:0] clamp_ops(
    input logic [NUMOPS_W-1:0] n,
    input int unsigned         lim
  );
    logic [NUMOPS_W-1:0] l;
    l = lim[NUMOPS_W-1:0];
    return (n > l) ? l : n;
  endfunction

endpackage

// File: rtl/arith_op_sequencer.sv
// Issues a packed opcode list to the arithmetic unit, chaining results.
// Optional step outputs: define ARITH_SEQ_STEP_OUT_EN.
module arith_op_sequencer
  import arith_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_OPS    = MAX_OPS_DEF,
  parameter int AU_LATENCY = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     OpA,
  input  logic [WIDTH-1:0]     OpB,
  input  logic [2*MAX_OPS-1:0] OpCodes,
  input  logic [NUMOPS_W-1:0]  NumOps,
  output logic [WIDTH-1:0]     AuA,
  output logic [WIDTH-1:0]     AuB,
  output logic [1:0]           AuOpCode,
  input  logic [WIDTH-1:0]     AuResult,
  output logic [WIDTH-1:0]     Result,
  output logic                 Busy,
  output logic                 Done
`ifdef ARITH_SEQ_STEP_OUT_EN
  ,
  output logic [WIDTH-1:0]     StepResult,
  output logic                 StepValid
`endif
);

  localparam int CW =
    (AU_LATENCY < 2) ? 1 : $clog2(AU_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(AU_LATENCY);

  seq_state_t state_q, state_d;

  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*MAX_OPS-1:0] ops_q, ops_d;
  logic [NUMOPS_W-1:0]  num_q, num_d;
  logic [NUMOPS_W-1:0]  k_q, k_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     aua_q, aua_d;
  logic [WIDTH-1:0]     aub_q, aub_d;
  au_op_t               auop_q, auop_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 done_q, done_d;

  logic [NUMOPS_W-1:0]  num_clamped;
  logic [NUMOPS_W-1:0]  k_next;
  logic [1:0]           op_sel;

  assign num_clamped = clamp_ops(NumOps, MAX_OPS);
  assign k_next      = k_q + 1'b1;

  // Pick the opcode slot addressed by the current op index.
  always_comb begin
    op_sel = 2'b00;
    for (int i = 0; i < MAX_OPS; i++) begin
      if (k_q == NUMOPS_W'(i)) op_sel = ops_q[2*i +: 2];
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (num_clamped == '0) state_d = S_DONE;
          else                   state_d = S_ISSUE;
        end
      end
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == CW'(1)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (k_next == num_q) state_d = S_DONE;
        else                 state_d = S_ISSUE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs driven from state and registered datapath.
  always_comb begin
    Busy     = (state_q != S_IDLE);
    Done     = done_q;
    Result   = res_q;
    AuA      = aua_q;
    AuB      = aub_q;
    AuOpCode = auop_q;
  end

  // Datapath next values: latch run, issue, count down, capture.
  always_comb begin
    acc_d  = acc_q;
    opb_d  = opb_q;
    ops_d  = ops_q;
    num_d  = num_q;
    k_d    = k_q;
    cnt_d  = cnt_q;
    aua_d  = aua_q;
    aub_d  = aub_q;
    auop_d = auop_q;
    res_d  = res_q;
    done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          acc_d = OpA;
          opb_d = OpB;
          ops_d = OpCodes;
          num_d = num_clamped;
          k_d   = '0;
        end
      end
      S_ISSUE: begin
        aua_d  = acc_q;
        aub_d  = opb_q;
        auop_d = au_op_t'(op_sel);
        cnt_d  = CNT_LOAD;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
      end
      S_CAPTURE: begin
        acc_d = AuResult;
        k_d   = k_next;
      end
      S_DONE: begin
        res_d  = acc_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything, including Result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_q  <= '0;
      opb_q  <= '0;
      ops_q  <= '0;
      num_q  <= '0;
      k_q    <= '0;
      cnt_q  <= '0;
      aua_q  <= '0;
      aub_q  <= '0;
      auop_q <= OP_ADD;
      res_q  <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      ops_q  <= ops_d;
      num_q  <= num_d;
      k_q    <= k_d;
      cnt_q  <= cnt_d;
      aua_q  <= aua_d;
      aub_q  <= aub_d;
      auop_q <= auop_d;
      res_q  <= res_d;
      done_q <= done_d;
    end
  end

`ifdef ARITH_SEQ_STEP_OUT_EN
  logic [WIDTH-1:0] step_q;
  logic             stepv_q;

  // Per-op result tap, valid the cycle after each capture.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      step_q  <= '0;
      stepv_q <= 1'b0;
    end else begin
      stepv_q <= (state_q == S_CAPTURE);
      if (state_q == S_CAPTURE) step_q <= AuResult;
    end
  end

  assign StepResult = step_q;
  assign StepValid  = stepv_q;
`endif

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Bench for arith_op_sequencer: two instances (unit latency 1 and 3)
// against a behavioural unit and a fold-over-opcodes reference.
module tb_arith_op_sequencer;
  import arith_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   start;
  logic [W-1:0] opa, opb;
  logic [15:0]  ops;
  logic [3:0]   numops;

  logic [W-1:0] aua [2];
  logic [W-1:0] aub [2];
  logic [W-1:0] res [2];
  logic [W-1:0] aures [2];
  logic [1:0]   auop [2];
  logic         busy [2];
  logic         done [2];
  logic [W-1:0] stepr [2];
  logic         stepv [2];

  int dcnt [2];
  int nchk = 0;
  int nerr = 0;

  function automatic logic [W-1:0] au_f(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic [1:0] op);
    logic [W-1:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a * b;
      default: r = a;
    endcase
    return r;
  endfunction

  arith_op_sequencer #(.WIDTH(W), .MAX_OPS(8), .AU_LATENCY(1)) u1 (
    .Clk(clk), .Reset(rst), .Start(start[0]),
    .OpA(opa), .OpB(opb), .OpCodes(ops), .NumOps(numops),
    .AuA(aua[0]), .AuB(aub[0]), .AuOpCode(auop[0]),
    .AuResult(aures[0]), .Result(res[0]),
    .Busy(busy[0]), .Done(done[0])
`ifdef ARITH_SEQ_STEP_OUT_EN
    , .StepResult(stepr[0]), .StepValid(stepv[0])
`endif
  );

  arith_op_sequencer #(.WIDTH(W), .MAX_OPS(8), .AU_LATENCY(3)) u3 (
    .Clk(clk), .Reset(rst), .Start(start[1]),
    .OpA(opa), .OpB(opb), .OpCodes(ops), .NumOps(numops),
    .AuA(aua[1]), .AuB(aub[1]), .AuOpCode(auop[1]),
    .AuResult(aures[1]), .Result(res[1]),
    .Busy(busy[1]), .Done(done[1])
`ifdef ARITH_SEQ_STEP_OUT_EN
    , .StepResult(stepr[1]), .StepValid(stepv[1])
`endif
  );

`ifndef ARITH_SEQ_STEP_OUT_EN
  initial begin
    stepr[0] = '0; stepr[1] = '0;
    stepv[0] = 1'b0; stepv[1] = 1'b0;
  end
`endif

  // Behavioural units: result valid L clocks after operands change.
  logic [W-1:0] p1;
  logic [W-1:0] p3 [3];
  always_ff @(posedge clk) begin
    p1    <= au_f(aua[0], aub[0], auop[0]);
    p3[0] <= au_f(aua[1], aub[1], auop[1]);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign aures[0] = p1;
  assign aures[1] = p3[2];

  always_ff @(posedge clk) begin
    if (done[0]) dcnt[0] <= dcnt[0] + 1;
    if (done[1]) dcnt[1] <= dcnt[1] + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int s, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [15:0] oc,
                     input logic [3:0] n, input bit poke);
    int L, nn, lat, cyc, d0;
    logic [W-1:0] acc;
    logic [W-1:0] exq [$];
    logic [W-1:0] gotq [$];
    logic [W-1:0] pa, pb;
    logic [1:0]   po;
    L   = (s == 0) ? 1 : 3;
    nn  = (n > 4'd8) ? 8 : int'(n);
    lat = 1 + nn * (L + 2);
    acc = a;
    for (int k = 0; k < nn; k++) begin
      acc = au_f(acc, b, oc[2*k +: 2]);
      exq.push_back(acc);
    end
    pa = aua[s]; pb = aub[s]; po = auop[s];
    d0 = dcnt[s];
    @(negedge clk);
    opa = a; opb = b; ops = oc; numops = n;
    start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
    check("busy_after_start", 32'(busy[s]), 32'd1);
    opa = W'($urandom); opb = W'($urandom);
    ops = 16'($urandom); numops = 4'($urandom);
    cyc = 0;
    while (cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (poke && cyc == 2) begin
        start[s] = 1'b1; opa = 16'd100;
      end
      if (poke && cyc == 3) start[s] = 1'b0;
      if (stepv[s]) gotq.push_back(stepr[s]);
      if (done[s]) break;
    end
    start[s] = 1'b0;
    check("done_latency", 32'(cyc), 32'(lat));
    check("result", 32'(res[s]), 32'(acc));
`ifdef ARITH_SEQ_STEP_OUT_EN
    check("step_count", 32'(gotq.size()), 32'(exq.size()));
    for (int i = 0; i < exq.size() && i < gotq.size(); i++)
      check("step_value", 32'(gotq[i]), 32'(exq[i]));
`endif
    if (nn == 0) begin
      check("au_a_held", 32'(aua[s]), 32'(pa));
      check("au_b_held", 32'(aub[s]), 32'(pb));
      check("au_op_held", 32'(auop[s]), 32'(po));
    end
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done[s]), 32'd0);
    check("busy_idle", 32'(busy[s]), 32'd0);
    check("done_pulses", 32'(dcnt[s] - d0), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    start = 2'b00;
    opa = '0; opb = '0; ops = '0; numops = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_aua", 32'(aua[s]), 32'd0);
      check("rst_aub", 32'(aub[s]), 32'd0);
      check("rst_auop", 32'(auop[s]), 32'd0);
      check("rst_result", 32'(res[s]), 32'd0);
      check("rst_busy", 32'(busy[s]), 32'd0);
      check("rst_done", 32'(done[s]), 32'd0);
    end
    rst = 1'b0;

    run(0, 16'd5, 16'd3, {14'd0, OP_ADD}, 4'd1, 1'b0);
    run(0, 16'd10, 16'd2,
        {10'd0, OP_ADD, OP_MUL, OP_SUB}, 4'd3, 1'b0);
    run(0, -16'sd7, 16'd9, 16'hFFFF, 4'd0, 1'b0);
    run(0, 16'd0, 16'd1, 16'h0000, 4'd15, 1'b0);
    run(0, 16'd10, 16'd2,
        {10'd0, OP_ADD, OP_MUL, OP_SUB}, 4'd3, 1'b1);
    run(1, 16'd10, 16'd2,
        {10'd0, OP_ADD, OP_MUL, OP_SUB}, 4'd3, 1'b0);

    // Abort the L=3 instance in the WAIT of its second op.
    @(negedge clk);
    opa = 16'd4; opb = 16'd6; ops = 16'h0000; numops = 4'd3;
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrun_busy", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_aua", 32'(aua[1]), 32'd0);
    check("abort_aub", 32'(aub[1]), 32'd0);
    check("abort_auop", 32'(auop[1]), 32'd0);
    check("abort_result", 32'(res[1]), 32'd0);
    check("abort_busy", 32'(busy[1]), 32'd0);
    check("abort_done", 32'(done[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(1, 16'd5, 16'd3, {14'd0, OP_ADD}, 4'd1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run(i % 2, W'($urandom), W'($urandom_range(0, 9)),
          16'($urandom), 4'($urandom_range(0, 15)), i[2]);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
